secuenciador_filtros: RTL and testbench

// - Sample-rate scheduler in front of UnidadFiltrado. Generates the sample tick, captures the ADC word into uk,

---
 rtl/secuenciador_filtros_pkg.sv | 34 +++
 rtl/secuenciador_filtros_if.sv | 33 +++
 rtl/secuenciador_filtros_mezclador_sat.sv | 26 ++
 rtl/secuenciador_filtros.sv | 157 +++++++++++++++
 tb/tb_secuenciador_filtros.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/secuenciador_filtros_pkg.sv
// Shared definitions for the sample-rate scheduler in front of UnidadFiltrado.
// Holds the sample width, default timing parameters, the FSM state type and the
// saturation helper used by the band mixer.
package secuenciador_filtros_pkg;

  localparam int N           = 16;    // sample width, signed two's complement
  localparam int CLK_DIV_DEF = 2268;  // clk cycles per sample period
  localparam int TIMEOUT_DEF = 1024;  // max cycles waiting for resultlisto

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MIX   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  typedef logic signed [N-1:0] sample_t;

  // Clamp limits expressed in the widened (N+2)-bit accumulator domain.
  localparam logic signed [N+1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};

  function automatic sample_t sat_n(input logic signed [N+1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[N-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[N-1:0];
    end else begin
      return v[N-1:0];
    end
  endfunction

endpackage

// File: rtl/secuenciador_filtros_if.sv
// Bus between the scheduler and its surroundings (ADC, UnidadFiltrado, DAC, control).
//   slave  : scheduler view  (drives uk/datolisto/dac_*/status)
//   master : environment view (drives run/clr_flags/band_en/adc_data/resultlisto/yk*)
interface secuenciador_filtros_if;
  import secuenciador_filtros_pkg::*;

  logic         run;
  logic         clr_flags;
  logic [2:0]   band_en;
  logic [N-1:0] adc_data;
  logic         resultlisto;
  logic [N-1:0] yk1;
  logic [N-1:0] yk2;
  logic [N-1:0] yk3;
  logic [N-1:0] uk;
  logic         datolisto;
  logic [N-1:0] dac_data;
  logic         dac_valid;
  logic         busy;
  logic         timeout_flag;
  logic [7:0]   overrun_cnt;

  modport slave (
    input  run, clr_flags, band_en, adc_data, resultlisto, yk1, yk2, yk3,
    output uk, datolisto, dac_data, dac_valid, busy, timeout_flag, overrun_cnt
  );

  modport master (
    output run, clr_flags, band_en, adc_data, resultlisto, yk1, yk2, yk3,
    input  uk, datolisto, dac_data, dac_valid, busy, timeout_flag, overrun_cnt
  );

endinterface

// File: rtl/secuenciador_filtros_mezclador_sat.sv
// Combinational 3-input masked adder with saturation.
//   band_en_i : per-band enable (bit0 = yk1, bit1 = yk2, bit2 = yk3)
//   yk1_i..3  : signed band samples
//   mix_o     : saturated sum of the enabled bands (0 when none enabled)
module secuenciador_filtros_mezclador_sat
  import secuenciador_filtros_pkg::*;
(
  input  logic [2:0]   band_en_i,
  input  logic [N-1:0] yk1_i,
  input  logic [N-1:0] yk2_i,
  input  logic [N-1:0] yk3_i,
  output logic [N-1:0] mix_o
);

  logic signed [N+1:0] t1, t2, t3, sum;

  // Two guard bits are enough for three N-bit terms, so the sum never wraps.
  always_comb begin
    t1    = band_en_i[0] ? {{2{yk1_i[N-1]}}, yk1_i} : '0;
    t2    = band_en_i[1] ? {{2{yk2_i[N-1]}}, yk2_i} : '0;
    t3    = band_en_i[2] ? {{2{yk3_i[N-1]}}, yk3_i} : '0;
    sum   = t1 + t2 + t3;
    mix_o = sat_n(sum);
  end

endmodule

// File: rtl/secuenciador_filtros.sv
// Sample-rate scheduler in front of UnidadFiltrado.
// Divides clk down to the sample tick, captures the ADC word into uk, pulses
// datolisto, waits for resultlisto, latches yk1..yk3, mixes the enabled bands
// with saturation and presents one DAC word per sample. Flags overruns (tick
// while a sample is in flight) and timeouts (resultlisto never arrives).
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave modport (control, ADC, filter handshake, DAC, status)
module secuenciador_filtros
  import secuenciador_filtros_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                   clk,
  input logic                   reset,
  secuenciador_filtros_if.slave bus
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [N-1:0]        uk_q, uk_d;
  logic [N-1:0]        dac_q, dac_d;
  logic [N-1:0]        yk1_q, yk1_d, yk2_q, yk2_d, yk3_q, yk3_d;
  logic                to_q, to_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                tick, timeout_ev, overrun_ev;
  logic [N-1:0]        mix;

  assign tick = bus.run & (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = '0;
    if (bus.run && (div_cnt_q != DIV_LAST)) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  secuenciador_filtros_mezclador_sat u_mix (
    .band_en_i (bus.band_en),
    .yk1_i     (yk1_q),
    .yk2_i     (yk2_q),
    .yk3_i     (yk3_q),
    .mix_o     (mix)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    uk_d       = uk_q;
    dac_d      = dac_q;
    yk1_d      = yk1_q;
    yk2_d      = yk2_q;
    yk3_d      = yk3_q;
    timeout_ev = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          uk_d    = bus.adc_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.resultlisto) begin
          yk1_d   = bus.yk1;
          yk2_d   = bus.yk2;
          yk3_d   = bus.yk3;
          state_d = ST_MIX;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            timeout_ev = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_MIX: begin
        dac_d   = mix;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Any tick outside IDLE is dropped, including one landing on the timeout cycle.
  assign overrun_ev = tick & (state_q != ST_IDLE);

  // A same-cycle event takes precedence over clr_flags.
  always_comb begin
    to_d = to_q;
    if (timeout_ev) begin
      to_d = 1'b1;
    end else if (bus.clr_flags) begin
      to_d = 1'b0;
    end

    ovr_d = ovr_q;
    if (overrun_ev) begin
      if (bus.clr_flags) begin
        ovr_d = 8'd1;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end else if (bus.clr_flags) begin
      ovr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      wait_cnt_q <= '0;
      uk_q       <= '0;
      dac_q      <= '0;
      yk1_q      <= '0;
      yk2_q      <= '0;
      yk3_q      <= '0;
      to_q       <= 1'b0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      uk_q       <= uk_d;
      dac_q      <= dac_d;
      yk1_q      <= yk1_d;
      yk2_q      <= yk2_d;
      yk3_q      <= yk3_d;
      to_q       <= to_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.uk           = uk_q;
  assign bus.datolisto    = (state_q == ST_ISSUE);
  assign bus.dac_data     = dac_q;
  assign bus.dac_valid    = (state_q == ST_OUT);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.timeout_flag = to_q;
  assign bus.overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_secuenciador_filtros.sv
// Bench for secuenciador_filtros: behavioural UnidadFiltrado with programmable
// latency plus a transaction-timeline reference model, checked every cycle.
module tb_secuenciador_filtros;
  import secuenciador_filtros_pkg::*;

  localparam int CD = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset;

  secuenciador_filtros_if bus_if();

  secuenciador_filtros #(.CLK_DIV(CD), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_dato = 0;
  int n_dv = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Filter model state
  typedef struct {
    int          t;
    logic [15:0] y1;
    logic [15:0] y2;
    logic [15:0] y3;
  } resp_t;
  resp_t pend[$];
  int          lat = 4;
  bit          mute = 1'b0;
  bit          spur_en = 1'b0;
  bit          yk_dir = 1'b0;
  logic [15:0] dy1 = '0, dy2 = '0, dy3 = '0;

  // Reference model: expected outputs plus the predicted event timeline
  bit          armed = 1'b0;
  logic [15:0] m_uk = '0, m_dac = '0;
  logic [15:0] m_y1 = '0, m_y2 = '0, m_y3 = '0;
  bit          m_to = 1'b0;
  int          m_ovr = 0;
  int          m_runidx = 0;
  int          m_dl = -1, m_resp = -1, m_mix = -1, m_dv = -1, m_busy_end = -1, m_to_last = -1;

  function automatic bit m_busy(input int c);
    return (c >= m_dl) && (c <= m_busy_end);
  endfunction

  function automatic logic [15:0] rnd_y();
    case ($urandom_range(0, 2))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 2000));
      default: return 16'(-$urandom_range(0, 2000));
    endcase
  endfunction

  function automatic logic [15:0] ref_mix(input logic [2:0] en, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
    int s = 0;
    if (en[0]) s += int'($signed(a));
    if (en[1]) s += int'($signed(b));
    if (en[2]) s += int'($signed(c));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // One clock: filter drives its outputs, model advances, outputs are checked.
  task automatic tick_cycle();
    bit bsy, tk;
    bus_if.resultlisto = 1'b0;
    bus_if.yk1 = rnd_y();
    bus_if.yk2 = rnd_y();
    bus_if.yk3 = rnd_y();
    if (pend.size() > 0 && pend[0].t == cyc) begin
      bus_if.resultlisto = 1'b1;
      bus_if.yk1 = pend[0].y1;
      bus_if.yk2 = pend[0].y2;
      bus_if.yk3 = pend[0].y3;
      void'(pend.pop_front());
    end else if (spur_en && !m_busy(cyc) && $urandom_range(0, 7) == 0) begin
      bus_if.resultlisto = 1'b1;
    end

    if (reset) begin
      m_uk = '0; m_dac = '0; m_to = 1'b0; m_ovr = 0; m_runidx = 0;
      m_dl = -1; m_resp = -1; m_mix = -1; m_dv = -1; m_busy_end = -1; m_to_last = -1;
      pend.delete();
      armed = 1'b1;
    end else begin
      bsy = m_busy(cyc);
      tk  = bus_if.run && (m_runidx % CD == CD - 1);
      if (cyc == m_resp) begin
        m_y1 = bus_if.yk1; m_y2 = bus_if.yk2; m_y3 = bus_if.yk3;
      end
      if (cyc == m_mix) m_dac = ref_mix(bus_if.band_en, m_y1, m_y2, m_y3);
      if (tk && bsy) m_ovr = bus_if.clr_flags ? 1 : (m_ovr < 255 ? m_ovr + 1 : 255);
      else if (bus_if.clr_flags) m_ovr = 0;
      if (cyc == m_to_last) m_to = 1'b1;
      else if (bus_if.clr_flags) m_to = 1'b0;
      if (tk && !bsy) begin
        m_uk = bus_if.adc_data;
        m_dl = cyc + 1;
        if (mute) begin
          m_to_last  = cyc + 1 + TO;
          m_busy_end = m_to_last;
        end else begin
          m_resp     = cyc + 1 + lat;
          m_mix      = m_resp + 1;
          m_dv       = m_resp + 2;
          m_busy_end = m_dv;
        end
      end
      m_runidx = bus_if.run ? m_runidx + 1 : 0;
    end

    @(negedge clk);
    cyc++;
    if (armed) begin
      check_val("uk",           32'(bus_if.uk),           32'(m_uk));
      check_val("datolisto",    32'(bus_if.datolisto),    32'(cyc == m_dl));
      check_val("dac_data",     32'(bus_if.dac_data),     32'(m_dac));
      check_val("dac_valid",    32'(bus_if.dac_valid),    32'(cyc == m_dv));
      check_val("busy",         32'(bus_if.busy),         32'(m_busy(cyc)));
      check_val("timeout_flag", 32'(bus_if.timeout_flag), 32'(m_to));
      check_val("overrun_cnt",  32'(bus_if.overrun_cnt),  32'(m_ovr));
    end
    if (bus_if.datolisto === 1'b1) begin
      n_dato++;
      if (!mute) pend.push_back('{cyc + lat, yk_dir ? dy1 : rnd_y(),
                                  yk_dir ? dy2 : rnd_y(), yk_dir ? dy3 : rnd_y()});
    end
    if (bus_if.dac_valid === 1'b1) n_dv++;
  endtask

  task automatic set_mode(input bit mu, input int l);
    int i = 0;
    bus_if.run = 1'b0;
    bus_if.clr_flags = 1'b0;
    while (m_busy(cyc) && i < 60) begin
      tick_cycle();
      i++;
    end
    check_val("idle_reached", 32'(bus_if.busy), 32'(0));
    mute = mu;
    lat  = l;
  endtask

  task automatic rand_inputs();
    bus_if.adc_data  = 16'($urandom);
    bus_if.band_en   = 3'($urandom_range(0, 7));
    bus_if.clr_flags = ($urandom_range(0, 15) == 0);
    bus_if.run       = ($urandom_range(0, 31) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    int start, hit;
    reset = 1'b1;
    bus_if.run = 1'b0; bus_if.clr_flags = 1'b0; bus_if.band_en = 3'b111;
    bus_if.adc_data = '0; bus_if.resultlisto = 1'b0;
    bus_if.yk1 = '0; bus_if.yk2 = '0; bus_if.yk3 = '0;
    repeat (3) tick_cycle();
    reset = 1'b0;
    spur_en = 1'b1;
    n_dato = 0;
    repeat (100) tick_cycle();
    check_val("no_dato_run0", 32'(n_dato), 32'(0));

    // Basic sample path
    yk_dir = 1'b1; dy1 = 16'd100; dy2 = 16'd200; dy3 = 16'd300;
    lat = 4; bus_if.adc_data = 16'h1234; bus_if.band_en = 3'b111; bus_if.run = 1'b1;
    n_dato = 0;
    repeat (40) tick_cycle();
    check_val("dato_count", 32'(n_dato), 32'(5));
    check_val("uk_1234", 32'(bus_if.uk), 32'h1234);
    check_val("dac_600", 32'(bus_if.dac_data), 32'd600);

    // Saturation and masking
    dy1 = 16'h7000; dy2 = 16'h7000; dy3 = 16'h7000;
    repeat (24) tick_cycle();
    check_val("sat_pos", 32'(bus_if.dac_data), 32'h7FFF);
    dy1 = 16'h9000; dy2 = 16'h9000; dy3 = 16'h9000;
    repeat (24) tick_cycle();
    check_val("sat_neg", 32'(bus_if.dac_data), 32'h8000);
    dy1 = 16'd1000; dy2 = 16'hFFFB; dy3 = 16'd7777; bus_if.band_en = 3'b010;
    repeat (24) tick_cycle();
    check_val("band_010", 32'(bus_if.dac_data), 32'hFFFB);
    bus_if.band_en = 3'b000;
    repeat (24) tick_cycle();
    check_val("band_000", 32'(bus_if.dac_data), 32'h0000);

    // Randomised traffic at several latencies
    yk_dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_mode(1'b0, (k == 0) ? 1 : (k == 1) ? 3 : 6);
      repeat (300) begin
        rand_inputs();
        tick_cycle();
      end
    end

    // Overrun with L > CLK_DIV, then clear
    set_mode(1'b0, 10);
    bus_if.run = 1'b1;
    repeat (100) begin
      bus_if.adc_data = 16'($urandom);
      tick_cycle();
    end
    check_val("ovr_seen", 32'(bus_if.overrun_cnt != 8'd0), 32'(1));
    set_mode(1'b0, 10);
    bus_if.clr_flags = 1'b1;
    tick_cycle();
    bus_if.clr_flags = 1'b0;
    check_val("ovr_cleared", 32'(bus_if.overrun_cnt), 32'(0));

    // Saturating overrun counter
    set_mode(1'b0, 19);
    bus_if.run = 1'b1;
    repeat (3300) tick_cycle();
    check_val("ovr_sat255", 32'(bus_if.overrun_cnt), 32'd255);

    // Known DAC value before the timeout
    set_mode(1'b0, 4);
    yk_dir = 1'b1; dy1 = 16'd100; dy2 = 16'd200; dy3 = 16'd300; bus_if.band_en = 3'b111;
    bus_if.clr_flags = 1'b1;
    tick_cycle();
    bus_if.clr_flags = 1'b0;
    bus_if.run = 1'b1;
    repeat (16) tick_cycle();
    check_val("pre_to_dac", 32'(bus_if.dac_data), 32'd600);

    // Timeout, with clr_flags landing on the timeout cycle
    set_mode(1'b1, 4);
    bus_if.run = 1'b1;
    start = m_to_last;
    hit = 0;
    for (int i = 0; i < 60 && hit == 0; i++) begin
      if (m_to_last > start && cyc == m_to_last) begin
        bus_if.clr_flags = 1'b1;
        hit = 1;
      end
      tick_cycle();
      bus_if.clr_flags = 1'b0;
    end
    check_val("to_clr_hit", 32'(hit), 32'(1));
    check_val("to_flag", 32'(bus_if.timeout_flag), 32'(1));
    check_val("to_dac_kept", 32'(bus_if.dac_data), 32'd600);
    repeat (20) tick_cycle();
    set_mode(1'b0, 4);
    bus_if.run = 1'b1;
    repeat (20) tick_cycle();

    // run dropped during WAIT
    set_mode(1'b0, 5);
    bus_if.run = 1'b1;
    start = m_dl;
    hit = 0;
    for (int i = 0; i < 40 && hit == 0; i++) begin
      tick_cycle();
      if (m_dl > start && cyc == m_dl + 1) hit = 1;
    end
    check_val("wait_reached", 32'(bus_if.busy & hit), 32'(1));
    bus_if.run = 1'b0;
    n_dv = 0; n_dato = 0;
    repeat (30) tick_cycle();
    check_val("rundrop_dv", 32'(n_dv), 32'(1));
    check_val("rundrop_dato", 32'(n_dato), 32'(0));

    // Reset asserted in MIX
    set_mode(1'b0, 4);
    bus_if.run = 1'b1;
    start = m_mix;
    hit = 0;
    for (int i = 0; i < 40 && hit == 0; i++) begin
      tick_cycle();
      if (m_mix > start && cyc == m_mix) hit = 1;
    end
    check_val("mix_reached", 32'(hit), 32'(1));
    reset = 1'b1;
    n_dv = 0;
    tick_cycle();
    reset = 1'b0;
    check_val("rst_mix_busy", 32'(bus_if.busy), 32'(0));
    repeat (5) tick_cycle();
    check_val("rst_mix_no_dv", 32'(n_dv), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
